l2_responder: RTL and testbench
===============================

# l2_responder

Next-level (L2) memory responder that serves 512-bit cache-line requests from the instruction and data L1 caches. It sits below both L1 caches: it accepts a 26-bit line address on either request port, arbitrates, waits a fixed access latency, and returns the line. It absorbs 512-bit write-backs from the data cache into a tagged backing store.

## Interface
Parameters:
- LADDR_W, 26, line-address width (32-bit byte address >> 6)
- LINE_BITS, 512, line width (64-byte line)
- IDX_W, 8, backing-store index width (2^IDX_W entries)
- LATENCY, 4, cycles from accept to response; legal range 1..15

Ports (clock, reset first):
- clk  in  1  single clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction-cache line read request
- i_ladd  in  LADDR_W  instruction line address
- i_rvalid  out  1  one-cycle response strobe, instruction port
- i_rdata  out  LINE_BITS  instruction line data, valid with i_rvalid
- d_req  in  1  data-cache request
- d_we  in  1  1 = write-back, 0 = read; qualified by d_req
- d_ladd  in  LADDR_W  data line address
- d_wdata  in  LINE_BITS  write-back line
- d_rvalid  out  1  one-cycle response/ack strobe, data port
- d_rdata  out  LINE_BITS  data line; on a write ack, the written line
- rd_count  out  32  total completed reads, both ports
- wr_count  out  32  total completed write-backs

## Operation
- Store: 2^IDX_W entries of {valid, tag[LADDR_W], line}. Index = ladd[IDX_W-1:0]; tag = full ladd.
- Read hit (valid and tag == ladd): return the stored line. Miss: return fill pattern {16{6'b0, ladd}}, with each 32-bit word the zero-extended line address. A read never allocates.
- Write: at response, write entry{1, ladd, wdata}. This overwrites any aliasing entry.
- Request protocol: the requester raises req with a stable address/we/wdata and holds them until its rvalid. It may drop req in the rvalid cycle or keep it high to issue the next request.
- FSM states:
  - IDLE: when any req is high, accept the winner, latch its port id, ladd, we and wdata, load the counter with LATENCY-1, and go to BUSY.
  - BUSY: decrement the counter. At 0, go to RESP.
  - RESP: perform the read or write, pulse the winner's rvalid with its rdata, and go to IDLE.
- Arbitration: 2-way round-robin on a last_grant register. The last_grant reset value is DATA, so the first simultaneous request goes to INS. A single requester always wins.
- Only the granted port's rvalid pulses. The other port's request stays pending.
- Counters are 32-bit and saturate at 0xFFFF_FFFF. Increment in the RESP cycle.
- rdata outputs hold their last value between strobes.

## Timing
- Accept edge T (IDLE, req high). rvalid is high during the cycle after edge T+LATENCY, i.e. LATENCY+1 cycles after req is first sampled.
- Next accept is the edge after the rvalid cycle. Peak throughput is one request per LATENCY+2 cycles.
- Read-after-write to the same line: the write commits in RESP, so a following read returns the new data.
- Reset values: i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0, rd_count=0, wr_count=0, FSM=IDLE, all valid bits=0, last_grant=DATA.
- Reset mid-transaction: the in-flight request is dropped with no rvalid and no store update. The requester must re-issue.
- req changing while not granted is ignored until the next IDLE sample.

## Configuration
- L2_STATS_EN defined: rd_count and wr_count are implemented as above.
- L2_STATS_EN undefined: counter registers are removed and both outputs are tied to 32'd0.

## Structure
- Package l2_pkg holds:
  - LADDR_W and LINE_BITS constants
  - the state type {IDLE, BUSY, RESP}
  - the port-id type {PORT_INS, PORT_DATA}
  - the fill-pattern function
- Sub-module l2_arb: 2-way round-robin arbiter (req pair, grant enable, last_grant register, one-hot grant out).

## Test plan
- Reset, then i_req with i_ladd=26'h0000123 -> i_rvalid exactly 5 cycles later (LATENCY=4), i_rdata={16{32'h0000_0123}}, rd_count=1.
- d write ladd=26'h0000040, wdata={16{32'hDEADBEEF}}, then d read of the same line -> d_rdata={16{32'hDEADBEEF}}, wr_count=1, rd_count=1.
- i_req and d_req rise together after reset -> INS served first. DATA rvalid follows 6 cycles after the INS rvalid. A second simultaneous pair is served DATA first.
- Alias: write ladd=26'h0000140, then read 26'h0000040 (same index) -> fill pattern {16{32'h0000_0040}}.
- clear_n pulsed during BUSY -> no rvalid, counters 0, a re-issued read of the written line returns the fill pattern.
- Build without L2_STATS_EN, run 10 reads -> rd_count=wr_count=0 throughout, data behaviour unchanged.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 responder: line geometry, FSM states,
// port ids and the miss fill pattern.
package l2_pkg;

  localparam int LADDR_W   = 26;
  localparam int LINE_BITS = 512;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} l2_state_e;
  typedef enum logic {PORT_INS = 1'b0, PORT_DATA = 1'b1} l2_port_e;

  // Miss data: every 32-bit word carries the zero-extended line address.
  function automatic logic [LINE_BITS-1:0] fill_line(input logic [LADDR_W-1:0] ladd);
    return {(LINE_BITS/32){{(32-LADDR_W){1'b0}}, ladd}};
  endfunction

endpackage

// File: rtl/l2_arb.sv
// 2-way round-robin arbiter between the instruction (bit 0) and data (bit 1)
// request lines; last_grant only moves when a grant is actually taken.
module l2_arb (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  import l2_pkg::*;

  l2_port_e last_grant;

  always_comb begin
    gnt = req;
    if (&req) gnt = (last_grant == PORT_DATA) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)          last_grant <= PORT_DATA;
    else if (en && |req)   last_grant <= gnt[1] ? PORT_DATA : PORT_INS;
  end

endmodule

// File: rtl/l2_responder.sv
// L2 line responder for the I/D L1 caches: arbitrate, wait LATENCY, serve a
// tagged backing store. Define L2_STATS_EN to build the rd/wr completion counters.
module l2_responder #(
  parameter int LADDR_W   = l2_pkg::LADDR_W,
  parameter int LINE_BITS = l2_pkg::LINE_BITS,
  parameter int IDX_W     = 8,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 i_req,
  input  logic [LADDR_W-1:0]   i_ladd,
  output logic                 i_rvalid,
  output logic [LINE_BITS-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [LADDR_W-1:0]   d_ladd,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic                 d_rvalid,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
);
  import l2_pkg::*;

  localparam int ENTRIES = 1 << IDX_W;

  l2_state_e            state;
  logic [3:0]           cnt;
  l2_port_e             port_q;
  logic [LADDR_W-1:0]   ladd_q;
  logic                 we_q;
  logic [LINE_BITS-1:0] wdata_q;

  logic [ENTRIES-1:0]   valid;
  logic [LADDR_W-1:0]   tag_mem  [ENTRIES];
  logic [LINE_BITS-1:0] line_mem [ENTRIES];

  logic [1:0]           gnt;
  logic [IDX_W-1:0]     idx;
  logic                 hit;
  logic                 respond;
  logic [LINE_BITS-1:0] resp_line;

  l2_arb u_arb (
    .clk     (clk),
    .clear_n (clear_n),
    .req     ({d_req, i_req}),
    .en      (state == IDLE),
    .gnt     (gnt)
  );

  assign idx       = ladd_q[IDX_W-1:0];
  assign hit       = valid[idx] && (tag_mem[idx] == ladd_q);
  // The response is registered on the edge leaving BUSY so rvalid lines up with RESP.
  assign respond   = (state == BUSY) && (cnt == 4'd0);
  assign resp_line = we_q ? wdata_q : (hit ? line_mem[idx] : fill_line(ladd_q));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      cnt      <= '0;
      port_q   <= PORT_INS;
      ladd_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: if (|gnt) begin
          port_q  <= gnt[1] ? PORT_DATA : PORT_INS;
          ladd_q  <= gnt[1] ? d_ladd : i_ladd;
          we_q    <= gnt[1] & d_we;
          wdata_q <= d_wdata;
          cnt     <= 4'(LATENCY - 1);
          state   <= BUSY;
        end
        BUSY: if (cnt == 4'd0) begin
          state <= RESP;
          if (port_q == PORT_INS) begin
            i_rvalid <= 1'b1;
            i_rdata  <= resp_line;
          end else begin
            d_rvalid <= 1'b1;
            d_rdata  <= resp_line;
          end
        end else begin
          cnt <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)              valid      <= '0;
    else if (respond && we_q)  valid[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (respond && we_q) begin
      tag_mem[idx]  <= ladd_q;
      line_mem[idx] <= wdata_q;
    end
  end

`ifdef L2_STATS_EN
  logic [31:0] rd_q, wr_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rd_q <= '0;
      wr_q <= '0;
    end else if (respond) begin
      if (we_q) wr_q <= (wr_q == 32'hFFFF_FFFF) ? wr_q : wr_q + 32'd1;
      else      rd_q <= (rd_q == 32'hFFFF_FFFF) ? rd_q : rd_q + 32'd1;
    end
  end

  assign rd_count = rd_q;
  assign wr_count = wr_q;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_l2_responder.sv
// Randomized self-checking bench for l2_responder against a line-store model.
module tb_l2_responder;

`ifdef L2_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [25:0]  i_ladd = '0, d_ladd = '0;
  logic [511:0] d_wdata = '0;
  logic         i_rvalid, d_rvalid;
  logic [511:0] i_rdata, d_rdata;
  logic [31:0]  rd_count, wr_count;

  int checks = 0;
  int passed = 0;

  l2_responder dut (
    .clk(clk), .clear_n(clear_n),
    .i_req(i_req), .i_ladd(i_ladd), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_ladd(d_ladd), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Reference store: index -> (tag, line), filled only by write-backs.
  logic [25:0]  m_tag  [int];
  logic [511:0] m_line [int];
  int m_rd = 0, m_wr = 0;

  function automatic logic [511:0] fill(input logic [25:0] a);
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = {6'b0, a};
    return r;
  endfunction

  function automatic logic [511:0] model_read(input logic [25:0] a);
    int i = int'(a[7:0]);
    if (m_tag.exists(i) && m_tag[i] == a) return m_line[i];
    return fill(a);
  endfunction

  function automatic void model_write(input logic [25:0] a, input logic [511:0] d);
    m_tag[int'(a[7:0])]  = a;
    m_line[int'(a[7:0])] = d;
  endfunction

  function automatic void model_reset();
    m_tag.delete();
    m_line.delete();
    m_rd = 0;
    m_wr = 0;
  endfunction

  function automatic logic [31:0] exp_rd();
    return STATS ? 32'(m_rd) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_wr();
    return STATS ? 32'(m_wr) : 32'd0;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // Run one request on one port; lat is cycles from raising req to seeing rvalid.
  task automatic issue(input bit port, input bit we, input logic [25:0] a,
                       input logic [511:0] wd, output int lat,
                       output logic [511:0] data, output bit other);
    other = 1'b0;
    lat   = -1;
    data  = '0;
    if (!port) begin
      i_ladd = a; i_req = 1'b1;
    end else begin
      d_ladd = a; d_we = we; d_wdata = wd; d_req = 1'b1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (port ? i_rvalid : d_rvalid) other = 1'b1;
      if (port ? d_rvalid : i_rvalid) begin
        lat  = n;
        data = port ? d_rdata : i_rdata;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({i_rvalid, d_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {i_rvalid, d_rvalid});
    else passed++;
    checks++;
    if (i_rdata !== 512'd0 || d_rdata !== 512'd0) $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_rdata[31:0], d_rdata[31:0]);
    else passed++;
    checks++;
    if (rd_count !== 32'd0 || wr_count !== 32'd0) $display("FAIL reset_counts: got rd=%0d wr=%0d expected 0", rd_count, wr_count);
    else passed++;
    clear_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read();
    int lat; logic [511:0] got; bit other;
    logic [511:0] exp = model_read(26'h0000123);
    issue(1'b0, 1'b0, 26'h0000123, '0, lat, got, other);
    m_rd++;
    checks++;
    if (lat !== LAT + 1) $display("FAIL read_latency: got %0d expected %0d", lat, LAT + 1);
    else passed++;
    checks++;
    if (got !== exp || got !== {16{32'h0000_0123}}) $display("FAIL read_fill: got %h expected %h", got, exp);
    else passed++;
    checks++;
    if (other) $display("FAIL read_other_port: got d_rvalid pulse expected none");
    else passed++;
    checks++;
    if (rd_count !== exp_rd()) $display("FAIL read_rd_count: got %0d expected %0d", rd_count, exp_rd());
    else passed++;
  endtask

  task automatic test_write_read();
    int lat; logic [511:0] got; bit other;
    logic [511:0] wd = {16{32'hDEADBEEF}};
    logic [511:0] i_hold = i_rdata;
    issue(1'b1, 1'b1, 26'h0000040, wd, lat, got, other);
    model_write(26'h0000040, wd);
    m_wr++;
    checks++;
    if (lat !== LAT + 1 || got !== wd) $display("FAIL write_ack: got lat=%0d data=%h expected lat=%0d data=%h", lat, got[31:0], LAT + 1, wd[31:0]);
    else passed++;
    checks++;
    if (wr_count !== exp_wr()) $display("FAIL write_wr_count: got %0d expected %0d", wr_count, exp_wr());
    else passed++;
    issue(1'b1, 1'b0, 26'h0000040, '0, lat, got, other);
    m_rd++;
    checks++;
    if (got !== model_read(26'h0000040)) $display("FAIL raw_data: got %h expected %h", got, model_read(26'h0000040));
    else passed++;
    checks++;
    if (rd_count !== exp_rd() || wr_count !== exp_wr()) $display("FAIL raw_counts: got rd=%0d wr=%0d expected rd=%0d wr=%0d", rd_count, wr_count, exp_rd(), exp_wr());
    else passed++;
    checks++;
    if (i_rdata !== i_hold) $display("FAIL i_rdata_hold: got %h expected %h", i_rdata[31:0], i_hold[31:0]);
    else passed++;
  endtask

  task automatic test_alias();
    int lat; logic [511:0] got; bit other;
    logic [511:0] wd = rnd_line();
    issue(1'b1, 1'b1, 26'h0000140, wd, lat, got, other);
    model_write(26'h0000140, wd);
    m_wr++;
    issue(1'b0, 1'b0, 26'h0000040, '0, lat, got, other);
    m_rd++;
    checks++;
    if (got !== model_read(26'h0000040) || got !== {16{32'h0000_0040}}) $display("FAIL alias_evict: got %h expected %h", got, model_read(26'h0000040));
    else passed++;
    issue(1'b0, 1'b0, 26'h0000140, '0, lat, got, other);
    m_rd++;
    checks++;
    if (got !== wd) $display("FAIL alias_hit: got %h expected %h", got, wd);
    else passed++;
  endtask

  // Both ports rise together after reset; INS keeps requesting once more, so the
  // second contended accept must go to DATA.
  task automatic test_arbitration();
    int ev_port[$], ev_cyc[$];
    int i_left = 2, d_left = 1;
    int exp_port[3] = '{0, 1, 0};
    int exp_cyc[3]  = '{LAT + 1, 2*LAT + 3, 3*LAT + 5};
    logic [25:0] ia1 = 26'($urandom());
    do_reset();
    i_ladd = 26'($urandom()); d_ladd = 26'($urandom()); d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (i_rvalid) begin
        ev_port.push_back(0); ev_cyc.push_back(n);
        m_rd++;
        checks++;
        if (i_rdata !== model_read(i_ladd)) $display("FAIL arb_i_data: got %h expected %h", i_rdata[31:0], model_read(i_ladd));
        else passed++;
        i_left--;
        if (i_left > 0) i_ladd = ia1;
        else i_req = 1'b0;
      end
      if (d_rvalid) begin
        ev_port.push_back(1); ev_cyc.push_back(n);
        m_rd++;
        checks++;
        if (d_rdata !== model_read(d_ladd)) $display("FAIL arb_d_data: got %h expected %h", d_rdata[31:0], model_read(d_ladd));
        else passed++;
        d_left--;
        d_req = 1'b0;
      end
      if (i_left == 0 && d_left == 0) break;
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ev_port.size() != 3) $display("FAIL arb_count: got %0d responses expected 3", ev_port.size());
    else passed++;
    for (int k = 0; k < 3; k++) begin
      int gp = (k < ev_port.size()) ? ev_port[k] : -1;
      int gc = (k < ev_cyc.size()) ? ev_cyc[k] : -1;
      checks++;
      if (gp != exp_port[k] || gc != exp_cyc[k]) $display("FAIL arb_order%0d: got port=%0d cycle=%0d expected port=%0d cycle=%0d", k, gp, gc, exp_port[k], exp_cyc[k]);
      else passed++;
    end
    checks++;
    if (rd_count !== exp_rd()) $display("FAIL arb_rd_count: got %0d expected %0d", rd_count, exp_rd());
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [511:0] got; bit other;
    bit seen = 1'b0;
    logic [511:0] wd = rnd_line();
    issue(1'b1, 1'b1, 26'h00002A5, wd, lat, got, other);
    model_write(26'h00002A5, wd);
    m_wr++;
    // In-flight read, then an in-flight write, each killed by an async pulse.
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin i_ladd = 26'h00002A5; i_req = 1'b1; end
      else begin d_ladd = 26'h00003A6; d_we = 1'b1; d_wdata = rnd_line(); d_req = 1'b1; end
      repeat (2) @(posedge clk);
      #1 clear_n = 1'b0;
      #3 clear_n = 1'b1;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      for (int n = 0; n < 8; n++) begin
        @(posedge clk); #1;
        if (i_rvalid || d_rvalid) seen = 1'b1;
      end
    end
    model_reset();
    checks++;
    if (seen) $display("FAIL reset_mid_rvalid: got rvalid pulse expected none");
    else passed++;
    checks++;
    if (rd_count !== 32'd0 || wr_count !== 32'd0) $display("FAIL reset_mid_counts: got rd=%0d wr=%0d expected 0", rd_count, wr_count);
    else passed++;
    issue(1'b0, 1'b0, 26'h00002A5, '0, lat, got, other);
    m_rd++;
    checks++;
    if (lat !== LAT + 1 || got !== model_read(26'h00002A5)) $display("FAIL reset_mid_reread: got lat=%0d data=%h expected lat=%0d data=%h", lat, got[31:0], LAT + 1, model_read(26'h00002A5));
    else passed++;
    issue(1'b1, 1'b0, 26'h00003A6, '0, lat, got, other);
    m_rd++;
    checks++;
    if (got !== model_read(26'h00003A6)) $display("FAIL reset_mid_nowrite: got %h expected %h", got[31:0], model_read(26'h00003A6));
    else passed++;
  endtask

  task automatic test_random();
    int lat; logic [511:0] got, exp, wd; bit other;
    for (int t = 0; t < 40; t++) begin
      bit port = 1'($urandom_range(0, 1));
      bit we   = port & 1'($urandom_range(0, 1));
      logic [25:0] a = {24'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      a = {a[25:2], 6'($urandom_range(0, 1)), a[1:0]};
      wd  = rnd_line();
      exp = we ? wd : model_read(a);
      issue(port, we, a, wd, lat, got, other);
      if (we) begin model_write(a, wd); m_wr++; end
      else m_rd++;
      checks++;
      if (lat !== LAT + 1 || other) $display("FAIL rnd_timing%0d: got lat=%0d other=%0b expected lat=%0d other=0", t, lat, other, LAT + 1);
      else passed++;
      checks++;
      if (got !== exp) $display("FAIL rnd_data%0d: got %h expected %h", t, got, exp);
      else passed++;
      checks++;
      if (rd_count !== exp_rd() || wr_count !== exp_wr()) $display("FAIL rnd_counts%0d: got rd=%0d wr=%0d expected rd=%0d wr=%0d", t, rd_count, wr_count, exp_rd(), exp_wr());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_read();
    test_alias();
    test_arbitration();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
